execute_stage: RTL
==================

// Module: execute_stage
// PURPOSE
//  Execute stage of the 5-stage pipelined RISC core; consumes the ID/EX outputs of the decode stage.
//  Selects forwarded operands, runs the ALU and resolves branches (taken flag + target PC).
//  Registers the results into the EX/MEM pipeline register that feeds the memory stage.
// PARAMETERS
//  DATA_W      32  datapath / PC width
//  REG_ADDR_W   5  register-index width
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       reset, asynchronous, active-high
//  RegWriteE    in   1       register write enable from decode
//  ResultSrcE   in   1       writeback source: 1 = memory, 0 = ALU
//  MemWriteE    in   1       store enable
//  ALUSrcE      in   1       ALU operand B: 1 = ImmExtE, 0 = forwarded rs2
//  BranchE      in   1       instruction is beq
//  ALUcontrolE  in   3       000 add, 001 sub, 010 and, 011 or, 101 slt (signed)
//  RD1E,RD2E    in   DATA_W  register-file read data
//  ImmExtE      in   DATA_W  sign-extended immediate
//  RdE          in   REG_ADDR_W  destination register
//  PCE,PCPlus4E in   DATA_W  instruction PC and PC+4
//  ForwardAE    in   2       operand-A select: 00 RD1E, 01 ResultW, 10 ALUResultM
//  ForwardBE    in   2       operand-B (pre-ALUSrc) select; same encoding
//  ResultW      in   DATA_W  writeback result (forward source)
//  PCSrcE       out  1       branch taken (combinational)
//  PCTargetE    out  DATA_W  PCE + ImmExtE (combinational)
//  RegWriteM,ResultSrcM,MemWriteM out 1  registered controls
//  RdM          out  REG_ADDR_W  registered destination
//  ALUResultM   out  DATA_W  registered ALU result
//  WriteDataM   out  DATA_W  registered forwarded rs2 (store data)
//  PCPlus4M     out  DATA_W  registered PC+4
// BEHAVIOUR
//  - Operand A: mux on ForwardAE; 2'b11 is treated as 00 (RD1E).
//  - Forwarded B: mux on ForwardBE, same rules; SrcB = ALUSrcE ? ImmExtE : forwarded B.
//  - ALU (combinational, DATA_W bits):
//      add/sub wrap modulo 2^DATA_W, no carry or overflow outputs.
//      slt: result = 1 if $signed(A) < $signed(B), else 0.
//      Codes 100, 110, 111 produce result 0.
//  - Zero = (ALU result == 0).
//  - PCSrcE = BranchE & Zero. PCTargetE = PCE + ImmExtE, wrapping.
//    Both are combinational with 0-cycle latency so the fetch stage redirects in the same cycle.
//  - EX/MEM register:
//      Every posedge clk captures RegWriteE, ResultSrcE, MemWriteE, RdE, ALU result,
//      forwarded B (not the immediate) and PCPlus4E.
//      1-cycle latency; no stall or enable; captures every cycle.
//  - Reset: all *M outputs go to 0 immediately on rst assertion (asynchronous).
//      A reset asserted mid-operation discards the instruction in flight.
//      With all-zero inputs after reset, RegWriteM and MemWriteM stay 0.
//  - Forwarding loop: the ALUResultM source is the block's own registered output, looped back internally.
//    No combinational path exists from ALUResultM to itself.
//  - No state machine; the pipeline register is the only state.
// STRUCTURE
//  - Shared package riscv_pkg:
//      ALU op constants: ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011, ALU_SLT=3'b101.
//      Forward-select constants: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
//  - One sub-module, alu (parameter DATA_W):
//      inputs A, B [DATA_W], ALUcontrol [3]; outputs Result [DATA_W], Zero.
//  - Forward muxes, branch adder and EX/MEM register stay in execute_stage.
// TESTING
//  1. Reset:
//     assert rst mid-cycle with RegWriteE=1 -> all *M outputs 0 before the next clk edge.
//  2. ALU ops, ALUSrcE=0:
//     RD1E=5, RD2E=2 -> ALUResultM 7 (add), 3 (sub), 0 (and), 7 (or), 0 (slt).
//     RD1E=32'hFFFFFFFF (-1), RD2E=2, slt -> 1.
//  3. Branch:
//     BranchE=1, sub, RD1E=RD2E=9, PCE=32'h40, ImmExtE=32'hFFFFFFF8 -> PCSrcE=1, PCTargetE=32'h38 same cycle.
//     RD2E=8 -> PCSrcE=0.
//  4. Forwarding:
//     cycle 1 add RD1E=3, RD2E=4 (ALUResultM=7).
//     Cycle 2 ForwardAE=10, RD2E=1, add -> ALUResultM=8.
//     ForwardBE=01 with ResultW=100, add, RD1E=5 -> 105.
//  5. Store path:
//     ALUSrcE=1, MemWriteE=1, ImmExtE=4, RD1E=32'h10, ForwardBE=01, ResultW=32'hAB
//     -> ALUResultM=32'h14, WriteDataM=32'hAB, MemWriteM=1.
//  6. Wrap and illegal op:
//     add 32'hFFFFFFFF+1 -> ALUResultM=0.
//     ALUcontrolE=3'b111 -> ALUResultM=0; with BranchE=1 -> PCSrcE=1.

Source files
------------

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared ALU op and forward-select constants for the pipelined core
package riscv_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational ALU: add, sub, and, or, signed slt; unused codes yield 0
module alu
    import riscv_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [2:0]        ALUcontrol,
    output logic [DATA_W-1:0] Result,
    output logic              Zero
);

    always_comb begin
        Result = '0;
        case (ALUcontrol)
            ALU_ADD: Result = A + B;
            ALU_SUB: Result = A - B;
            ALU_AND: Result = A & B;
            ALU_OR:  Result = A | B;
            ALU_SLT: Result = {{(DATA_W-1){1'b0}}, ($signed(A) < $signed(B))};
            default: Result = '0;
        endcase
    end

    assign Zero = (Result == '0);

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - EX stage: operand forwarding, ALU, branch resolve and EX/MEM register
module execute_stage
    import riscv_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RegWriteE,
    input  logic                  ResultSrcE,
    input  logic                  MemWriteE,
    input  logic                  ALUSrcE,
    input  logic                  BranchE,
    input  logic [2:0]            ALUcontrolE,
    input  logic [DATA_W-1:0]     RD1E,
    input  logic [DATA_W-1:0]     RD2E,
    input  logic [DATA_W-1:0]     ImmExtE,
    input  logic [REG_ADDR_W-1:0] RdE,
    input  logic [DATA_W-1:0]     PCE,
    input  logic [DATA_W-1:0]     PCPlus4E,
    input  logic [1:0]            ForwardAE,
    input  logic [1:0]            ForwardBE,
    input  logic [DATA_W-1:0]     ResultW,
    output logic                  PCSrcE,
    output logic [DATA_W-1:0]     PCTargetE,
    output logic                  RegWriteM,
    output logic                  ResultSrcM,
    output logic                  MemWriteM,
    output logic [REG_ADDR_W-1:0] RdM,
    output logic [DATA_W-1:0]     ALUResultM,
    output logic [DATA_W-1:0]     WriteDataM,
    output logic [DATA_W-1:0]     PCPlus4M
);

    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] fwd_b;
    logic [DATA_W-1:0] src_b;
    logic [DATA_W-1:0] alu_result;
    logic              zero;

    // Select code 2'b11 is unused and falls back to the register file value.
    always_comb begin
        src_a = RD1E;
        case (ForwardAE)
            FWD_WB:  src_a = ResultW;
            FWD_MEM: src_a = ALUResultM;
            default: src_a = RD1E;
        endcase
    end

    always_comb begin
        fwd_b = RD2E;
        case (ForwardBE)
            FWD_WB:  fwd_b = ResultW;
            FWD_MEM: fwd_b = ALUResultM;
            default: fwd_b = RD2E;
        endcase
    end

    assign src_b = ALUSrcE ? ImmExtE : fwd_b;

    alu #(
        .DATA_W(DATA_W)
    ) u_alu (
        .A         (src_a),
        .B         (src_b),
        .ALUcontrol(ALUcontrolE),
        .Result    (alu_result),
        .Zero      (zero)
    );

    // Same-cycle redirect to fetch.
    assign PCSrcE    = BranchE & zero;
    assign PCTargetE = PCE + ImmExtE;

    // Store data is the forwarded rs2, never the immediate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWriteM  <= 1'b0;
            ResultSrcM <= 1'b0;
            MemWriteM  <= 1'b0;
            RdM        <= '0;
            ALUResultM <= '0;
            WriteDataM <= '0;
            PCPlus4M   <= '0;
        end else begin
            RegWriteM  <= RegWriteE;
            ResultSrcM <= ResultSrcE;
            MemWriteM  <= MemWriteE;
            RdM        <= RdE;
            ALUResultM <= alu_result;
            WriteDataM <= fwd_b;
            PCPlus4M   <= PCPlus4E;
        end
    end

endmodule
